// File: rtl/toy_bus_dtcm_slave_bridge.sv
// DTCM terminal slave: ToyBusReq -> 1-cycle SRAM -> credit-protected ToyBusAck FIFO.
// Define TOY_BUS_DTCM_RSP_BYPASS_EN to let an empty FIFO forward the s1 response combinationally.
module toy_bus_dtcm_slave_bridge #(
  parameter int          ADDR_W    = 14,
  parameter int          RSP_DEPTH = 4,
  parameter logic [3:0]  NODE_ID   = 4'h3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_vld,
  output logic              in0_rdy,
  input  logic [31:0]       in0_addr,
  input  logic [3:0]        in0_strb,
  input  logic [31:0]       in0_data,
  input  logic              in0_opcode,
  input  logic [3:0]        in0_src_id,
  input  logic [3:0]        in0_tgt_id,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              out0_vld,
  input  logic              out0_rdy,
  output logic [31:0]       out0_data,
  output logic              out0_opcode,
  output logic [3:0]        out0_src_id,
  output logic [3:0]        out0_tgt_id
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic        opcode;
    logic [3:0]  tgt_id;
    logic [31:0] data;
  } rsp_t;

  logic                       s1_vld_q, s1_vld_d;
  logic                       s1_opcode_q, s1_opcode_d;
  logic [3:0]                 s1_tgt_id_q, s1_tgt_id_d;
  rsp_t [RSP_DEPTH-1:0]       fifo_q, fifo_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [CW:0]                credit;
  logic                       accept, empty, push, pop;
  rsp_t                       s1_rsp, head;
  logic                       unused_ok;

  assign unused_ok = ^{in0_tgt_id, in0_addr[31:ADDR_W+2], in0_addr[1:0]};

  // Credits cover queued entries plus the one in flight in s1, so an issued access always finds a slot.
  assign credit  = {1'b0, cnt_q} + {{CW{1'b0}}, s1_vld_q};
  assign in0_rdy = credit < (CW+1)'(RSP_DEPTH);
  assign accept  = in0_vld & in0_rdy;

  assign mem_en    = accept;
  assign mem_wen   = in0_opcode;
  assign mem_addr  = in0_addr[ADDR_W+1:2];
  assign mem_wstrb = in0_strb;
  assign mem_wdata = in0_data;

  assign s1_rsp = '{opcode: s1_opcode_q, tgt_id: s1_tgt_id_q,
                    data: s1_opcode_q ? 32'h0 : mem_rdata};
  assign empty  = (cnt_q == '0);
  assign pop    = ~empty & out0_rdy;

`ifdef TOY_BUS_DTCM_RSP_BYPASS_EN
  // An empty FIFO forwards s1 directly; the entry is still queued if the consumer stalls.
  assign push     = s1_vld_q & ~(empty & out0_rdy);
  assign out0_vld = ~empty | s1_vld_q;
  assign head     = empty ? s1_rsp : fifo_q[rd_ptr_q];
`else
  assign push     = s1_vld_q;
  assign out0_vld = ~empty;
  assign head     = fifo_q[rd_ptr_q];
`endif

  assign out0_data   = head.data;
  assign out0_opcode = head.opcode;
  assign out0_tgt_id = head.tgt_id;
  assign out0_src_id = NODE_ID;

  always_comb begin
    s1_vld_d    = accept;
    s1_opcode_d = accept ? in0_opcode : s1_opcode_q;
    s1_tgt_id_d = accept ? in0_src_id : s1_tgt_id_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = s1_rsp;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_opcode_q <= 1'b0;
      s1_tgt_id_q <= '0;
      fifo_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_opcode_q <= s1_opcode_d;
      s1_tgt_id_q <= s1_tgt_id_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule
